// File: rtl/tvbg_sequencer.sv
// Session sequencer for the TV-code playback controller: button debounce,
// start/retry/abort handling, loop gaps and status LEDs.
module tvbg_sequencer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int GAP_CYCLES      = 3000000,
  parameter int BLINK_CYCLES    = 3000000,
  parameter int MAX_RETRIES     = 2,
  parameter int START_TIMEOUT   = 8
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       button_in,
  input  logic       loop_in,
  output logic       ctrl_start_out,
  output logic       ctrl_reset_out,
  input  logic       ctrl_busy_in,
  input  logic       ctrl_fail_in,
  output logic       led_busy_out,
  output logic       led_fail_out,
  output logic [7:0] pass_count_out,
  output logic [2:0] state_out
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
  localparam int TO_W  = $clog2(START_TIMEOUT + 1);
  localparam int TM_A  = (GAP_W > BLK_W) ? GAP_W : BLK_W;
  localparam int TM_W  = (TM_A > TO_W) ? TM_A : TO_W;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [TM_W-1:0] GAP_LAST = TM_W'(GAP_CYCLES - 1);
  localparam logic [TM_W-1:0] BLK_LAST = TM_W'(BLINK_CYCLES - 1);
  localparam logic [TM_W-1:0] TO_LAST  = TM_W'(START_TIMEOUT - 1);
  localparam logic [TM_W-1:0] TM_ONE   = TM_W'(1);
  localparam logic [TM_W-1:0] TM_WAIT  = TM_W'(2);
  localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_GAP       = 3'd4,
    S_RECOVER   = 3'd5,
    S_ABORT     = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  logic            r_btn_s1, r_btn_s2, r_loop_s1, r_loop_s2;
  logic            r_deb, r_deb_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_press;

  state_t          r_state;
  logic [TM_W-1:0] r_timer;
  logic [3:0]      r_retry;
  logic [7:0]      r_pass;
  logic            r_ctrl_rst;
  logic            r_led_fail;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_loop_s1 <= 1'b0;
      r_loop_s2 <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_d   <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_btn_s1  <= button_in;
      r_btn_s2  <= r_btn_s1;
      r_loop_s1 <= loop_in;
      r_loop_s2 <= r_loop_s1;
      r_deb_d   <= r_deb;
      if (r_btn_s2 == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_deb    <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_ONE;
      end
    end
  end

  // Only the rising edge of the debounced level counts as a user action.
  assign w_press = r_deb & ~r_deb_d;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_retry    <= 4'd0;
      r_pass     <= 8'd0;
      r_ctrl_rst <= 1'b0;
      r_led_fail <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_retry <= 4'd0;
            r_timer <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (w_press) begin
            r_timer    <= '0;
            r_ctrl_rst <= 1'b1;
            r_state    <= S_ABORT;
          end else if (ctrl_busy_in) begin
            r_timer <= '0;
            r_state <= S_RUN;
          end else if (r_timer == TO_LAST) begin
            r_timer    <= '0;
            r_ctrl_rst <= 1'b1;
            r_state    <= S_RECOVER;
          end else begin
            r_timer <= r_timer + TM_ONE;
          end
        end
        S_RUN: begin
          r_timer <= '0;
          if (w_press) begin
            r_ctrl_rst <= 1'b1;
            r_state    <= S_ABORT;
          end else if (ctrl_fail_in) begin
            r_ctrl_rst <= 1'b1;
            r_state    <= S_RECOVER;
          end else if (!ctrl_busy_in) begin
            r_pass  <= r_pass + 8'd1;
            r_retry <= 4'd0;
            r_state <= r_loop_s2 ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (w_press || !r_loop_s2) begin
            r_timer <= '0;
            r_state <= S_IDLE;
          end else if (r_timer == GAP_LAST) begin
            r_timer <= '0;
            r_state <= S_START;
          end else begin
            r_timer <= r_timer + TM_ONE;
          end
        end
        S_RECOVER, S_ABORT: begin
          // Timer 0..1 covers the two reset cycles; at 2 it holds while busy drains.
          if (r_timer < TM_WAIT) begin
            r_timer <= r_timer + TM_ONE;
            if (r_timer == TM_ONE) r_ctrl_rst <= 1'b0;
          end else if (!ctrl_busy_in) begin
            r_timer <= '0;
            if (r_state == S_ABORT) begin
              r_state <= S_IDLE;
            end else if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 4'd1;
              r_state <= S_START;
            end else begin
              r_led_fail <= 1'b1;
              r_state    <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          if (w_press) begin
            r_retry    <= 4'd0;
            r_led_fail <= 1'b0;
            r_timer    <= '0;
            r_state    <= S_IDLE;
          end else if (r_timer == BLK_LAST) begin
            r_led_fail <= ~r_led_fail;
            r_timer    <= '0;
          end else begin
            r_timer <= r_timer + TM_ONE;
          end
        end
        default: begin
          r_timer <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrl_start_out = (r_state == S_START);
  assign ctrl_reset_out = r_ctrl_rst;
  assign led_busy_out   = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign led_fail_out   = r_led_fail;
  assign pass_count_out = r_pass;
  assign state_out      = r_state;

endmodule

// File: tb/tb_tvbg_sequencer.sv
// Bench for tvbg_sequencer: controller model, timestamp-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_tvbg_sequencer;

  localparam int D     = 4;
  localparam int GAPC  = 10;
  localparam int BLINK = 4;
  localparam int MAXR  = 2;
  localparam int TO    = 8;

  logic       clk;
  logic       rst;
  logic       button;
  logic       loop_sw;
  logic       ctrl_start_out;
  logic       ctrl_reset_out;
  logic       c_busy;
  logic       c_fail;
  logic       led_busy_out;
  logic       led_fail_out;
  logic [7:0] pass_count_out;
  logic [2:0] state_out;

  int tests;
  int fails;
  int edges;
  int n_start;
  int n_rst;

  logic fail_mode;
  logic never_busy;
  int   c_cnt;

  tvbg_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .GAP_CYCLES(GAPC),
    .BLINK_CYCLES(BLINK),
    .MAX_RETRIES(MAXR),
    .START_TIMEOUT(TO)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .button_in(button),
    .loop_in(loop_sw),
    .ctrl_start_out(ctrl_start_out),
    .ctrl_reset_out(ctrl_reset_out),
    .ctrl_busy_in(c_busy),
    .ctrl_fail_in(c_fail),
    .led_busy_out(led_busy_out),
    .led_fail_out(led_fail_out),
    .pass_count_out(pass_count_out),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Playback controller stand-in: busy one cycle after start, for 20 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy <= 1'b0;
      c_fail <= 1'b0;
      c_cnt  <= 0;
    end else if (ctrl_reset_out) begin
      c_busy <= 1'b0;
      c_fail <= 1'b0;
      c_cnt  <= 0;
    end else if (ctrl_start_out) begin
      if (!never_busy) begin
        c_busy <= 1'b1;
        c_cnt  <= 0;
      end
    end else if (c_busy) begin
      c_cnt <= c_cnt + 1;
      if (fail_mode && c_cnt == 4) c_fail <= 1'b1;
      if (c_cnt == 19) begin
        c_busy <= 1'b0;
        c_fail <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edges);
    end
  endtask

  // Reference model: states named by their debug code, timing by entry timestamp.
  int   m_st, m_enter, m_pass, m_retry, m_run;
  logic m_b1, m_b2, m_l1, m_l2, m_deb, m_deb_d;

  task automatic model_reset();
    m_st = 0; m_enter = 0; m_pass = 0; m_retry = 0; m_run = 0;
    m_b1 = 0; m_b2 = 0; m_l1 = 0; m_l2 = 0; m_deb = 0; m_deb_d = 0;
  endtask

  task automatic go(input int s, input int n);
    m_st = s;
    m_enter = n;
  endtask

  task automatic model_step(input int n);
    logic press, lp, done;
    press = m_deb && !m_deb_d;
    lp = m_l2;
    done = (n - m_enter >= 3) && !c_busy;
    case (m_st)
      0: if (press) begin m_retry = 0; go(1, n); end
      1: go(2, n);
      2: if (press) go(6, n); else if (c_busy) go(3, n); else if (n - m_enter == TO) go(5, n);
      3: if (press) go(6, n);
         else if (c_fail) go(5, n);
         else if (!c_busy) begin m_pass = (m_pass + 1) % 256; m_retry = 0; go(lp ? 4 : 0, n); end
      4: if (press || !lp) go(0, n); else if (n - m_enter == GAPC) go(1, n);
      5: if (done) begin
           if (m_retry < MAXR) begin m_retry++; go(1, n); end
           else go(7, n);
         end
      6: if (done) go(0, n);
      7: if (press) begin m_retry = 0; go(0, n); end
      default: go(0, n);
    endcase
    m_deb_d = m_deb;
    if (m_b2 != m_deb) begin
      m_run++;
      if (m_run == D) begin m_deb = m_b2; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_b2 = m_b1; m_b1 = button;
    m_l2 = m_l1; m_l1 = loop_sw;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        n_start = 0;
        n_rst = 0;
      end
      chk("state", 32'(state_out), 32'(m_st));
      chk("start", 32'(ctrl_start_out), 32'(m_st == 1));
      chk("creset", 32'(ctrl_reset_out), 32'((m_st == 5 || m_st == 6) && (edges - m_enter < 2)));
      chk("ledbusy", 32'(led_busy_out), 32'(m_st >= 1 && m_st <= 6));
      chk("ledfail", 32'(led_fail_out), 32'(m_st == 7 && ((edges - m_enter) / BLINK) % 2 == 0));
      chk("pass", 32'(pass_count_out), 32'(m_pass));
      if (!rst) begin
        if (ctrl_start_out) n_start++;
        if (ctrl_reset_out) n_rst++;
        model_step(edges + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int limit, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (state_out != 3'(s) && k < limit);
    tests++;
    if (state_out != 3'(s)) begin
      fails++;
      $display("FAIL %s: state_out=%0d, waited for %0d", nm, state_out, s);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    button = 1'b0;
    loop_sw = 1'b0;
    fail_mode = 1'b0;
    never_busy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  int e0, g, g2, f, w;

  initial begin
    rst = 1'b1;
    button = 1'b0;
    loop_sw = 1'b0;
    fail_mode = 1'b0;
    never_busy = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state_out), 0);
    chk("rst_start", 32'(ctrl_start_out), 0);
    chk("rst_creset", 32'(ctrl_reset_out), 0);
    chk("rst_ledbusy", 32'(led_busy_out), 0);
    chk("rst_ledfail", 32'(led_fail_out), 0);
    chk("rst_pass", 32'(pass_count_out), 0);
    rst = 1'b0;

    // Single pass, loop off
    repeat (2) tick();
    button = 1'b1;
    e0 = edges + 1;
    wait_state(1, 30, "single_start");
    chk("single_start_edge", 32'(edges), 32'(e0 + D + 2));
    repeat (2) tick();
    button = 1'b0;
    wait_state(3, 20, "single_run");
    wait_state(0, 60, "single_idle");
    #1;
    chk("single_pass", 32'(pass_count_out), 1);
    chk("single_nstart", 32'(n_start), 1);
    chk("single_ledbusy", 32'(led_busy_out), 0);

    // Loop mode: gap timing, then drop loop in the second gap
    do_reset();
    loop_sw = 1'b1;
    repeat (3) tick();
    button = 1'b1;
    wait_state(3, 40, "loop_run");
    tick();
    button = 1'b0;
    wait_state(4, 60, "loop_gap1");
    g = edges;
    wait_state(1, 20, "loop_start2");
    chk("loop_gap_len", 32'(edges), 32'(g + GAPC));
    wait_state(4, 60, "loop_gap2");
    g2 = edges;
    tick();
    loop_sw = 1'b0;
    wait_state(0, 10, "loop_idle");
    chk("loop_idle_edge", 32'(edges), 32'(g2 + 4));
    #1;
    chk("loop_pass", 32'(pass_count_out), 2);

    // Fail on every pass: two retries then FAULT
    do_reset();
    fail_mode = 1'b1;
    tick();
    button = 1'b1;
    wait_state(1, 30, "fail_start");
    repeat (2) tick();
    button = 1'b0;
    wait_state(7, 300, "fail_fault");
    f = edges;
    #1;
    chk("fail_nstart", 32'(n_start), 3);
    chk("fail_nreset", 32'(n_rst), 6);
    chk("fail_pass", 32'(pass_count_out), 0);
    chk("fail_led_on", 32'(led_fail_out), 1);
    repeat (4) tick();
    chk("fail_led_off", 32'(led_fail_out), 0);
    repeat (4) tick();
    chk("fail_led_on2", 32'(led_fail_out), 1);
    button = 1'b1;
    wait_state(0, 30, "fail_clear");
    #1;
    chk("fail_clear_led", 32'(led_fail_out), 0);
    repeat (2) tick();
    button = 1'b0;
    repeat (10) tick();

    // Abort during RUN
    do_reset();
    tick();
    button = 1'b1;
    wait_state(3, 40, "abort_run");
    tick();
    button = 1'b0;
    repeat (7) tick();
    button = 1'b1;
    wait_state(6, 30, "abort_enter");
    wait_state(0, 30, "abort_idle");
    #1;
    chk("abort_nreset", 32'(n_rst), 2);
    chk("abort_pass", 32'(pass_count_out), 0);
    button = 1'b0;
    repeat (15) tick();
    chk("abort_nstart", 32'(n_start), 1);

    // Three-cycle glitch is rejected
    do_reset();
    tick();
    button = 1'b1;
    repeat (3) tick();
    button = 1'b0;
    repeat (20) tick();
    chk("glitch_nstart", 32'(n_start), 0);
    chk("glitch_state", 32'(state_out), 0);

    // Controller never raises busy
    do_reset();
    never_busy = 1'b1;
    tick();
    button = 1'b1;
    wait_state(2, 30, "to_wait");
    w = edges;
    wait_state(5, 20, "to_recover");
    chk("to_edge", 32'(edges), 32'(w + TO));
    button = 1'b0;

    // Asynchronous reset in the middle of a run
    do_reset();
    tick();
    button = 1'b1;
    wait_state(3, 40, "ar_run1");
    tick();
    button = 1'b0;
    wait_state(0, 60, "ar_idle1");
    repeat (8) tick();
    button = 1'b1;
    wait_state(3, 40, "ar_run2");
    repeat (3) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    button = 1'b0;
    #1;
    chk("ar_state", 32'(state_out), 0);
    chk("ar_start", 32'(ctrl_start_out), 0);
    chk("ar_creset", 32'(ctrl_reset_out), 0);
    chk("ar_ledbusy", 32'(led_busy_out), 0);
    chk("ar_ledfail", 32'(led_fail_out), 0);
    chk("ar_pass", 32'(pass_count_out), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
